// File: rtl/matmul_pkg.sv
// matmul_pkg: shared FSM encoding, default sizes and helpers for the matmul job arbiter
package matmul_pkg;
    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 64;
    localparam int JOBS_W      = 8;

    typedef enum logic [1:0] {IDLE, GRANT, RUN, ACK} state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/matmul_job_arbiter_if.sv
// matmul_job_arbiter_if: requester and engine handshake bundle for the arbiter
interface matmul_job_arbiter_if
    import matmul_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic              eng_start;
    logic              eng_done;
    logic              busy;
    logic              err;
    logic [JOBS_W-1:0] jobs_done;

    modport master (input req, eng_done, output gnt, ack, eng_start, busy, err, jobs_done);
    modport slave  (output req, eng_done, input gnt, ack, eng_start, busy, err, jobs_done);
endinterface

// File: rtl/matmul_rr_pick.sv
// matmul_rr_pick: combinational round-robin pick, first request at or above ptr with wrap
module matmul_rr_pick
    import matmul_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
)(
    input  logic [NREQ-1:0]        req,
    input  logic [idx_w(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]        win,
    output logic                   valid
);
    localparam int PW = idx_w(NREQ);

    logic [PW-1:0] j;

    // scan from ptr upward, the first set request wins
    always_comb begin
        win   = '0;
        valid = 1'b0;
        j     = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = PW'((int'(ptr) + i) % NREQ);
            if (!valid && req[j]) begin
                win[j] = 1'b1;
                valid  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/matmul_job_arbiter.sv
// matmul_job_arbiter: round-robin owner of one matmul engine; MATMUL_ARB_TIMEOUT_EN adds a RUN watchdog
module matmul_job_arbiter
    import matmul_pkg::*;
#(
    parameter int NREQ        = NREQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
)(
    input  logic                 clk,
    input  logic                 rst,
    matmul_job_arbiter_if.master bus
);
    localparam int PW = idx_w(NREQ);

    state_t            state, state_n;
    logic [PW-1:0]     ptr, ptr_n, own;
    logic [NREQ-1:0]   win, gnt_n, ack_n;
    logic              win_v, tmo, tmo_ack, tmo_n, start_n, err_n;
    logic [JOBS_W-1:0] jobs_n;

    matmul_rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .win   (win),
        .valid (win_v)
    );

`ifdef MATMUL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    // cycles spent in RUN, restarting from 0 on every job
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= (state == RUN) ? cnt + CW'(1) : '0;
    end

    assign tmo = (state == RUN) && !bus.eng_done && (cnt == CW'(TIMEOUT_CYC - 1));
`else
    localparam int unused_timeout = TIMEOUT_CYC;

    assign tmo = 1'b0;
`endif

    // owner index recovered from the one-hot grant
    always_comb begin
        own = '0;
        for (int i = 0; i < NREQ; i++)
            if (bus.gnt[i]) own = PW'(i);
    end

    // job sequencing; new requests only matter in IDLE
    always_comb begin
        state_n = (state == IDLE)  ? (win_v ? GRANT : IDLE) :
                  (state == GRANT) ? RUN :
                  (state == RUN)   ? ((bus.eng_done || tmo) ? ACK : RUN) : IDLE;
    end

    // next values of the registered outputs
    always_comb begin
        gnt_n   = (state == IDLE) ? win : (state == ACK) ? '0 : bus.gnt;
        ack_n   = (state == RUN && state_n == ACK) ? bus.gnt : '0;
        start_n = (state == GRANT);
        err_n   = bus.err | tmo;
        tmo_n   = (state == RUN) ? tmo : tmo_ack;
        jobs_n  = bus.jobs_done + JOBS_W'(state == ACK && !tmo_ack);
        ptr_n   = (state == ACK) ? ((int'(own) == NREQ - 1) ? '0 : own + PW'(1)) : ptr;
    end

    // state and output registers; reset aborts any job without an ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            tmo_ack       <= 1'b0;
            bus.gnt       <= '0;
            bus.ack       <= '0;
            bus.eng_start <= 1'b0;
            bus.busy      <= 1'b0;
            bus.err       <= 1'b0;
            bus.jobs_done <= '0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            tmo_ack       <= tmo_n;
            bus.gnt       <= gnt_n;
            bus.ack       <= ack_n;
            bus.eng_start <= start_n;
            bus.busy      <= (state_n != IDLE);
            bus.err       <= err_n;
            bus.jobs_done <= jobs_n;
        end
    end
endmodule

// File: tb/tb_matmul_job_arbiter.sv
// tb_matmul_job_arbiter: directed jobs checked each cycle against a job-level model plus literal expectations
module tb_matmul_job_arbiter;
    import matmul_pkg::*;

    localparam int N       = 4;
    localparam int TMO_CYC = 64;
`ifdef MATMUL_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    matmul_job_arbiter_if #(.NREQ(N)) bus ();

    matmul_job_arbiter #(.NREQ(N), .TIMEOUT_CYC(TMO_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // job-level model: phase 0 waiting, 1 granted, 2 engine running, 3 acknowledging
    int m_ph, m_own, m_ptr, m_run, rq;
    bit m_tmo;
    int e_gnt, e_ack, e_start, e_busy, e_err, e_jobs;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = 0; m_own = 0; m_ptr = 0; m_run = 0; m_tmo = 1'b0;
            e_gnt = 0; e_ack = 0; e_start = 0; e_busy = 0; e_err = 0; e_jobs = 0;
        end else begin
            e_ack = 0;
            e_start = 0;
            rq = int'(bus.req);
            if (m_ph == 0) begin
                for (int k = 0; k < N; k++)
                    if (m_ph == 0 && ((rq >> ((m_ptr + k) % N)) & 1) != 0) begin
                        m_own = (m_ptr + k) % N;
                        e_gnt = 1 << m_own;
                        m_ph  = 1;
                    end
            end else if (m_ph == 1) begin
                e_start = 1;
                m_run   = 0;
                m_ph    = 2;
            end else if (m_ph == 2) begin
                m_run++;
                m_tmo = TMO_EN && !bus.eng_done && (m_run == TMO_CYC);
                if (bus.eng_done || m_tmo) begin
                    e_ack = 1 << m_own;
                    if (m_tmo) e_err = 1;
                    m_ph = 3;
                end
            end else begin
                e_gnt = 0;
                m_ptr = (m_own + 1) % N;
                if (!m_tmo) e_jobs = (e_jobs + 1) % 256;
                m_ph = 0;
            end
            e_busy = (m_ph != 0) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("gnt",       32'(bus.gnt),       e_gnt);
            chk("ack",       32'(bus.ack),       e_ack);
            chk("eng_start", 32'(bus.eng_start), e_start);
            chk("busy",      32'(bus.busy),      e_busy);
            chk("err",       32'(bus.err),       e_err);
            chk("jobs_done", 32'(bus.jobs_done), e_jobs);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!bus.eng_start && n < 10) begin
            tick();
            n++;
        end
        chk("start_seen", 32'(bus.eng_start), 1);
    endtask

    task automatic job(input int own, input int d);
        wait_start();
        repeat (d) tick();
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        chk("job_ack", 32'(bus.ack), 1 << own);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req      = '0;
        bus.eng_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("rst_gnt",  32'(bus.gnt), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_jobs", 32'(bus.jobs_done), 0);
        chk("rst_err",  32'(bus.err), 0);

        // single request, engine done after 5 running cycles
        bus.req = 4'b0001;
        tick();
        chk("t1_gnt", 32'(bus.gnt), 1);
        tick();
        chk("t1_start", 32'(bus.eng_start), 1);
        repeat (5) tick();
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        bus.req      = '0;
        chk("t1_ack", 32'(bus.ack), 1);
        tick();
        chk("t1_jobs", 32'(bus.jobs_done), 1);
        chk("t1_gnt_clr", 32'(bus.gnt), 0);

        // lone requester wins despite ptr=1, and holding req re-requests
        bus.req = 4'b0001;
        job(0, 1);
        job(0, 0);
        bus.req = '0;
        tick();

        // engine done while idle is ignored
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        tick();
        chk("idle_done_busy", 32'(bus.busy), 0);
        chk("idle_done_jobs", 32'(bus.jobs_done), 3);

        // fairness from reset: order 0,1,2,3,0,1,2,3
        reset_dut();
        bus.req = 4'b1111;
        for (int i = 0; i < 8; i++) job(i % 4, i % 3);
        bus.req = '0;
        tick();
        chk("fair_jobs", 32'(bus.jobs_done), 8);

        // owner drops req mid-run, job still completes
        bus.req = 4'b0100;
        wait_start();
        tick();
        bus.req = '0;
        repeat (2) tick();
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        chk("drop_ack", 32'(bus.ack), 4);
        tick();
        chk("drop_gnt", 32'(bus.gnt), 0);
        chk("drop_jobs", 32'(bus.jobs_done), 9);

        // reset during RUN clears outputs at once; next grant starts from 0
        bus.req = 4'b0010;
        wait_start();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rstrun_gnt",  32'(bus.gnt), 0);
        chk("rstrun_busy", 32'(bus.busy), 0);
        chk("rstrun_ack",  32'(bus.ack), 0);
        chk("rstrun_jobs", 32'(bus.jobs_done), 0);
        bus.req = 4'b1111;
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("rstrun_next_gnt", 32'(bus.gnt), 1);
        job(0, 0);
        bus.req = '0;
        tick();

        // jobs_done wraps after 256 jobs
        reset_dut();
        bus.req = 4'b0001;
        for (int i = 0; i < 256; i++) job(0, 0);
        bus.req = '0;
        tick();
        chk("wrap_jobs", 32'(bus.jobs_done), 0);

        // engine never answers
        bus.req = 4'b0001;
        wait_start();
        bus.req = '0;
`ifdef MATMUL_ARB_TIMEOUT_EN
        n = 0;
        while (!bus.ack && n < 100) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, TMO_CYC);
        chk("tmo_ack", 32'(bus.ack), 1);
        chk("tmo_err", 32'(bus.err), 1);
        tick();
        chk("tmo_jobs", 32'(bus.jobs_done), 0);
        bus.req = 4'b0001;
        job(0, 2);
        bus.req = '0;
        tick();
        chk("tmo_err_sticky", 32'(bus.err), 1);
        chk("tmo_after_jobs", 32'(bus.jobs_done), 1);
`else
        n = 0;
        repeat (100) begin
            tick();
            if (bus.ack != '0) n++;
        end
        chk("nodone_acks", n, 0);
        chk("nodone_busy", 32'(bus.busy), 1);
        chk("nodone_err",  32'(bus.err), 0);
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        chk("nodone_ack", 32'(bus.ack), 1);
        tick();
        chk("nodone_jobs", 32'(bus.jobs_done), 1);
`endif

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/matmul_job_arbiter.md
MATMUL_JOB_ARBITER -- requirements
Module: matmul_job_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one matrix-multiply engine.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64: maximum engine run cycles before abort; used only with the timeout feature compiled in.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NREQ  per-requester job request, level, held until matching ack.
REQ-006 gnt  output  NREQ  one-hot grant, held for the whole job.
REQ-007 ack  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-008 eng_start  output  1  one-cycle start pulse to the engine.
REQ-009 eng_done  input  1  one-cycle done pulse from the engine.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 err  output  1  sticky timeout flag.
REQ-012 jobs_done  output  8  completed-job count, wraps 255 -> 0.

Function
REQ-013 SHALL implement states IDLE, GRANT, RUN, ACK; all outputs registered.
REQ-014 IDLE: if any req bit set, SHALL pick a winner round-robin, searching from index ptr upward with wrap, set gnt to that bit, and go to GRANT.
REQ-015 Grant latency SHALL be 1 cycle: gnt high on the edge after req is seen in IDLE.
REQ-016 GRANT: SHALL pulse eng_start for exactly 1 cycle and go to RUN.
REQ-017 RUN: on eng_done SHALL go to ACK; gnt stays asserted.
REQ-018 ACK: SHALL pulse ack[owner] for 1 cycle, clear gnt, set ptr = owner+1 mod NREQ, increment jobs_done, and return to IDLE.
REQ-019 Minimum job cycle SHALL be 4 clocks; the next grant comes no earlier than 1 cycle after ack.
REQ-020 Deasserting req of the owner during GRANT or RUN SHALL NOT abort the job; the job completes and ack still pulses.
REQ-021 eng_done outside RUN SHALL be ignored.
REQ-022 Simultaneous new requests while busy SHALL be held off, not queued; they are arbitrated on the next IDLE.
REQ-023 A requester still asserting req in the cycle after its ack SHALL be treated as a new request.
REQ-024 When only one requester is active, it SHALL win every time, regardless of ptr.

Reset
REQ-025 On rst: state IDLE, gnt=0, ack=0, eng_start=0, err=0, jobs_done=0, ptr=0; takes effect immediately, including mid-job.
REQ-026 A job aborted by rst SHALL NOT produce an ack.

Configuration
REQ-027 Macro MATMUL_ARB_TIMEOUT_EN defined: SHALL count RUN cycles from 0. If the count reaches TIMEOUT_CYC without eng_done, SHALL set err (sticky until rst) and go to ACK. In that ACK, ack still pulses and jobs_done is NOT incremented.
REQ-028 Macro undefined: SHALL have no counter and err tied 0; RUN waits indefinitely for eng_done.

Structure
REQ-029 Shared package matmul_pkg SHALL hold the state encoding, NREQ default, TIMEOUT_CYC default and jobs_done width.
REQ-030 Round-robin selection SHALL be a combinational sub-module matmul_rr_pick: inputs req and ptr; outputs one-hot winner and valid.

Verification
REQ-031 Single request: req=0001, engine done 5 cycles after eng_start -> gnt=0001 at +1, eng_start at +2, ack[0] 1 cycle after eng_done, jobs_done=1.
REQ-032 Fairness: req=1111 held, 8 jobs -> grant order 0,1,2,3,0,1,2,3; jobs_done=8.
REQ-033 Owner drops req mid-RUN -> job completes, ack[owner] pulses, gnt=0 next cycle.
REQ-034 rst asserted in RUN -> all outputs 0 asynchronously, no ack, next grant goes to requester 0.
REQ-035 With MATMUL_ARB_TIMEOUT_EN, eng_done never sent -> after 64 RUN cycles err=1, ack pulses, jobs_done unchanged; err stays 1 through later good jobs.
REQ-036 jobs_done wrap: 256 jobs -> jobs_done=0; eng_done pulsed in IDLE -> no state change.
